la_split2: RTL and testbench
============================

Name: la_split2

Overview:
- Registered 1-to-2 stream splitter with valid/ready handshake. One input stream is routed beat-by-beat to output A or output B by a per-beat select bit.
- Used wherever a single producer feeds two consumers, such as fanning a request stream into two pipelines.
- Each output has its own 2-entry elastic buffer. The block sustains one beat per cycle and a stall on one output never blocks traffic bound for the other.

Parameters:
- DW, 32, data width in bits (legal range 1 to 1024).
- PROP, "DEFAULT", implementation property string passed through to cell selection; no functional effect.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  reset is synchronous and active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- in_data  input  DW  input payload.
- in_sel  input  1  destination of the beat: 0 selects A, 1 selects B.
- a_valid  output  1  output A beat present.
- a_ready  input  1  consumer A accepts.
- a_data  output  DW  output A payload.
- b_valid  output  1  output B beat present.
- b_ready  input  1  consumer B accepts.
- b_data  output  DW  output B payload.

Behaviour:
- Reset, applied while reset is high at a clk edge:
  - both buffers go to EMPTY;
  - a_valid=0 and b_valid=0;
  - a_data and b_data are held at 0.
  - Reset in mid-operation discards all buffered beats, with no partial delivery.
  - in_ready=0 during every cycle in which reset is high.
- Buffer state per output: EMPTY(0), ONE(1), TWO(2). It is a 2-slot FIFO with head and tail pointers.
- Transitions for one buffer, with push = in_valid & in_ready & routed-here and pop = x_valid & x_ready:
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to TWO; pop without push goes to EMPTY; push with pop stays in ONE.
  - TWO: pop goes to ONE. Push is impossible because in_ready is 0.
- in_ready = ~reset & (in_sel ? (stateB != TWO) : (stateA != TWO)). It depends combinationally on in_sel only, and never on a_ready or b_ready.
- Latency: an accepted beat appears on its output in the cycle after acceptance, giving 1-cycle minimum latency. There is no combinational path from input to output.
- x_valid = (state != EMPTY). x_data is driven from the head slot only.
- x_data is stable while x_valid=1 and x_ready=0.
- Ordering is preserved per output. No ordering holds between A and B.
- A beat accepted while its target buffer is in TWO state is impossible. The buffer must never overflow or underflow.
- Throughput: with both consumers always ready, the block accepts 1 beat per cycle indefinitely in any in_sel pattern.
- in_sel and in_data are sampled only on an accepted cycle. Their values are don't-care when in_valid=0.

Optional Feature:
- The macro is LA_SPLIT2_BROADCAST_EN.
- When the macro is defined:
  - an extra input port in_bcast (1 bit) is added;
  - a beat with in_bcast=1 is pushed into both buffers in the same cycle, and in_sel is ignored;
  - in_ready for that beat is ~reset & (stateA != TWO) & (stateB != TWO), so both buffers must have space. Acceptance is atomic and never partial.
- When the macro is undefined, the in_bcast port is absent and the behaviour is exactly as above.

Decomposition:
- Shared package/include la_split2_pkg:
  - buffer state constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - the select encoding constants SEL_A=1'b0, SEL_B=1'b1.
- One sub-module, la_split2_slot: a 2-entry elastic FIFO with push, full, valid, ready and data.
  - It is instantiated twice (A and B).
  - The top level holds only routing and in_ready logic.

Test Plan:
- Reset: hold reset=1 for 3 cycles with in_valid=1 → in_ready=0, a_valid=0, b_valid=0. Send 2 beats, then assert reset for 1 cycle → both valid=0 next cycle and the old beats are never delivered.
- Steady alternation: a_ready=b_ready=1; send data 0x1..0x10 with in_sel toggling 0,1,0,… → A receives 0x1,0x3,…,0xF and B receives 0x2,…,0x10; in_ready stays 1 throughout; each beat appears exactly 1 cycle after acceptance.
- Backpressure on A: a_ready=0, b_ready=1; send 0xA0,0xA1 to A, then 0xA2 to A → in_ready=0 on 0xA2. Switch in_sel to B for beat 0xB0 → accepted immediately. Release a_ready → A delivers 0xA0 then 0xA1, then 0xA2 is accepted.
- Data stability: stall b_ready=0 for 5 cycles with B holding 0x55 → b_data stays 0x55 and b_valid stays 1 for all 5 cycles.
- Simultaneous push and pop: A in ONE state, a_ready=1, push 0x77 to A in the same cycle → A state remains ONE and A delivers the old head, then 0x77.
- Broadcast (with LA_SPLIT2_BROADCAST_EN): with B full, send in_bcast=1 data 0xCC → in_ready=0 and no push to A. Drain one B entry → beat accepted and 0xCC appears on both A and B.

Source files
------------

// File: rtl/la_split2_pkg.sv
// Shared types and constants for the la_split2 1-to-2 stream splitter.
package la_split2_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/la_split2_slot.sv
// Two-entry elastic FIFO feeding one output of la_split2.
// Output data comes straight from the head slot register, so there is no input-to-output path.
module la_split2_slot
  import la_split2_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data
);

  buf_state_t    state;
  logic          head;
  logic          tail;
  logic [DW-1:0] mem [2];
  logic          pop;
  logic          wr;

  assign valid = (state != ST_EMPTY);
  assign full  = (state == ST_TWO);
  assign pop   = valid & ready;
  // A push into a full buffer is dropped here as a safety net; the top already withholds in_ready.
  assign wr    = push & ~full;
  assign data  = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case (state)
        ST_EMPTY: if (wr) state <= ST_ONE;
        ST_ONE: begin
          if (wr && !pop)      state <= ST_TWO;
          else if (pop && !wr) state <= ST_EMPTY;
        end
        ST_TWO:   if (pop) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/la_split2.sv
// Registered 1-to-2 stream splitter: routes each input beat to A or B by in_sel.
// Optional broadcast (macro LA_SPLIT2_BROADCAST_EN) adds in_bcast to push one beat into both outputs.
module la_split2
  import la_split2_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter string       PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
`ifdef LA_SPLIT2_BROADCAST_EN
  input  logic          in_bcast,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [DW-1:0] a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [DW-1:0] b_data
);

  logic full_a;
  logic full_b;
  logic bcast;
  logic space;
  logic accept;
  logic push_a;
  logic push_b;

  // in_ready looks only at buffer fullness, never at the consumer ready inputs.
  always_comb begin
    bcast = 1'b0;
`ifdef LA_SPLIT2_BROADCAST_EN
    bcast = in_bcast;
`endif
    if (bcast)                space = ~full_a & ~full_b;
    else if (in_sel == SEL_B) space = ~full_b;
    else                      space = ~full_a;
    in_ready = ~reset & space;
    accept   = in_valid & in_ready;
    push_a   = accept & (bcast | (in_sel == SEL_A));
    push_b   = accept & (bcast | (in_sel == SEL_B));
  end

  la_split2_slot #(.DW(DW)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_data),
    .full      (full_a),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data)
  );

  la_split2_slot #(.DW(DW)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_data),
    .full      (full_b),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data)
  );

endmodule

// File: tb/tb_la_split2.sv
// Directed self-checking bench for la_split2 (broadcast checks run when LA_SPLIT2_BROADCAST_EN is defined).
module tb_la_split2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        ar;
    logic        br;
    logic        ir;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
  } vec_t;

  vec_t tbl [21];

  always #5 clk = ~clk;

  la_split2 #(.DW(32), .PROP("DEFAULT")) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef LA_SPLIT2_BROADCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check at negedge, advance to the next posedge+1.
  task automatic cyc(input string name, input logic v, input logic sel, input logic bc,
                     input logic [31:0] d, input logic ar, input logic br,
                     input logic ir, input logic av, input logic [31:0] ad,
                     input logic bv, input logic [31:0] bd);
    in_valid = v;
    in_sel   = sel;
    in_bcast = bc;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    @(negedge clk);
    check({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    check({name, ".a_valid"}, {31'd0, a_valid}, {31'd0, av});
    check({name, ".b_valid"}, {31'd0, b_valid}, {31'd0, bv});
    if (av) check({name, ".a_data"}, a_data, ad);
    if (bv) check({name, ".b_data"}, b_data, bd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Backpressure on A, independent B traffic, B stall stability, A push+pop in ONE.
    tbl[0]  = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0};
    tbl[5]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h55};
    tbl[14] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h55};
    tbl[15] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h66, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 32'h77, 1'b1, 1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};

    reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_bcast = 1'b0;
    in_data = 32'h1234; a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.in_ready", {31'd0, in_ready}, 32'd0);
      check("rst.a_valid", {31'd0, a_valid}, 32'd0);
      check("rst.b_valid", {31'd0, b_valid}, 32'd0);
      check("rst.a_data", a_data, 32'd0);
      check("rst.b_data", b_data, 32'd0);
      @(posedge clk);
    end
    #1;
    reset = 1'b0;

    // Reset mid-operation drops buffered beats.
    cyc("mid0", 1'b1, 1'b0, 1'b0, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
    cyc("mid1", 1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
    reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    @(negedge clk);
    check("mid.rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("mid.after", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mid.a_data_zero", a_data, 32'd0);
    check("mid.b_data_zero", b_data, 32'd0);

    // Alternating A/B at full rate; each beat shows up exactly one cycle after acceptance.
    for (int i = 1; i <= 16; i++) begin
      logic        pa;
      logic        pb;
      logic [31:0] pd;
      pd = 32'(i - 1);
      pa = (i > 1) && ((i - 1) % 2 == 1);
      pb = (i > 1) && ((i - 1) % 2 == 0);
      cyc("alt", 1'b1, 1'((i - 1) % 2), 1'b0, 32'(i), 1'b1, 1'b1, 1'b1, pa, pd, pb, pd);
    end
    cyc("alt.tail", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    cyc("alt.idle", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 21; i++)
      cyc($sformatf("tbl%0d", i), tbl[i].v, tbl[i].sel, 1'b0, tbl[i].d, tbl[i].ar, tbl[i].br,
          tbl[i].ir, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd);

`ifdef LA_SPLIT2_BROADCAST_EN
    // Fill B, then a broadcast beat must wait until B has room and land in both outputs.
    cyc("bc.f0", 1'b1, 1'b1, 1'b0, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("bc.f1", 1'b1, 1'b1, 1'b0, 32'hB2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hB1);
    cyc("bc.c0", 1'b1, 1'b0, 1'b1, 32'hCC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB1);
    cyc("bc.c1", 1'b1, 1'b0, 1'b1, 32'hCC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB1);
    cyc("bc.c2", 1'b1, 1'b0, 1'b1, 32'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hB2);
    cyc("bc.c3", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hCC, 1'b1, 32'hCC);
    cyc("bc.c4", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
